trap_ctrl: RTL and testbench

Exception/trap sequencer that sits directly upstream of the decode-stage CSR file. It collects exception requests from fetch, decode and memory, picks the oldest one, and produces the one-cycle exception record (valid, code, pc, value) that the CSR file latches into mepc/mcause. It then flushes and stalls the pipeline for a programmable drain period and redirects fetch to the trap vector, or to mepc_i on mret.

---
 rtl/trap_ctrl.sv | 152 +++++++++++++++
 tb/tb_trap_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap sequencer: picks the oldest exception (mem > decode > fetch), emits a one-cycle record, flushes, then redirects fetch.
// Latency: request -> xcpt_o 1 cycle; request -> redirect_valid_o FLUSH_CYCLES+1 cycles.
// Backpressure: redirect_valid_o/redirect_pc_o are held in REDIRECT until redirect_ready_i; all requests are ignored outside IDLE.
//
// Ports:
//   clk_i, rstn_i                         clock, async active-low reset
//   if_* / id_* / mem_*                   exception/mret requests with pc and trap-value sources
//   mepc_i                                mret return target from the CSR file
//   redirect_ready_i                      fetch accepts the redirect
//   xcpt_o, xcpt_code_o/pc_o/value_o      one-cycle exception record to the CSR file (zero when not valid)
//   flush_o, stall_o                      pipeline kill / freeze
//   redirect_valid_o, redirect_pc_o       fetch redirect request (pc zero when not valid)
module trap_ctrl #(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        if_xcpt_i,
  input  logic [4:0]  if_xcpt_code_i,
  input  logic [31:0] if_pc_i,
  input  logic        id_illegal_i,
  input  logic        id_ecall_i,
  input  logic        id_ebreak_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_instr_i,
  input  logic        id_mret_i,
  input  logic        mem_ld_misalign_i,
  input  logic        mem_st_misalign_i,
  input  logic [31:0] mem_pc_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mepc_i,
  input  logic        redirect_ready_i,
  output logic        xcpt_o,
  output logic [4:0]  xcpt_code_o,
  output logic [31:0] xcpt_pc_o,
  output logic [31:0] xcpt_value_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        xcpt_q;
  logic [4:0]  code_q;
  logic [31:0] pc_q, value_q, target_q;

  // Oldest-first exception selection; mem instructions are the oldest in flight.
  logic        sel_vld;
  logic [4:0]  sel_code;
  logic [31:0] sel_pc, sel_value;

  always_comb begin
    sel_vld   = 1'b1;
    sel_code  = 5'd0;
    sel_pc    = 32'd0;
    sel_value = 32'd0;
    if (mem_ld_misalign_i) begin
      sel_code = 5'd4;  sel_pc = mem_pc_i; sel_value = mem_addr_i;
    end else if (mem_st_misalign_i) begin
      sel_code = 5'd6;  sel_pc = mem_pc_i; sel_value = mem_addr_i;
    end else if (id_illegal_i) begin
      sel_code = 5'd2;  sel_pc = id_pc_i;  sel_value = id_instr_i;
    end else if (id_ebreak_i) begin
      sel_code = 5'd3;  sel_pc = id_pc_i;
    end else if (id_ecall_i) begin
      sel_code = 5'd11; sel_pc = id_pc_i;
    end else if (if_xcpt_i) begin
      sel_code = if_xcpt_code_i; sel_pc = if_pc_i; sel_value = if_pc_i;
    end else begin
      sel_vld = 1'b0;
    end
  end

  // An exception alongside mret wins: the mret belongs to a flushed instruction.
  logic take_xcpt, take_mret;
  assign take_xcpt = (state_q == IDLE) && sel_vld;
  assign take_mret = (state_q == IDLE) && !sel_vld && id_mret_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    flush_o          = 1'b0;
    stall_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'd0;
    case (state_q)
      IDLE: begin
        if (take_xcpt || take_mret) begin
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        stall_o = 1'b1;
        if (cnt_q == 4'd0) state_d = REDIRECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      REDIRECT: begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        if (redirect_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Record and redirect target are captured only on the IDLE sampling edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      xcpt_q   <= 1'b0;
      code_q   <= 5'd0;
      pc_q     <= 32'd0;
      value_q  <= 32'd0;
      target_q <= 32'd0;
    end else begin
      xcpt_q <= take_xcpt;
      if (take_xcpt) begin
        code_q   <= sel_code;
        pc_q     <= sel_pc;
        value_q  <= sel_value;
        target_q <= TRAP_VECTOR;
      end else if (take_mret) begin
        target_q <= mepc_i;
      end
    end
  end

  assign xcpt_o       = xcpt_q;
  assign xcpt_code_o  = xcpt_q ? code_q  : 5'd0;
  assign xcpt_pc_o    = xcpt_q ? pc_q    : 32'd0;
  assign xcpt_value_o = xcpt_q ? value_q : 32'd0;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        if_xcpt_i;
  logic [4:0]  if_xcpt_code_i;
  logic [31:0] if_pc_i;
  logic        id_illegal_i, id_ecall_i, id_ebreak_i, id_mret_i;
  logic [31:0] id_pc_i, id_instr_i;
  logic        mem_ld_misalign_i, mem_st_misalign_i;
  logic [31:0] mem_pc_i, mem_addr_i, mepc_i;
  logic        redirect_ready_i;
  logic        xcpt_o, flush_o, stall_o, redirect_valid_o;
  logic [4:0]  xcpt_code_o;
  logic [31:0] xcpt_pc_o, xcpt_value_o, redirect_pc_o;

  int n_cmp = 0;
  int n_err = 0;

  trap_ctrl #(.TRAP_VECTOR(32'h0000_0100), .FLUSH_CYCLES(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .if_xcpt_i(if_xcpt_i), .if_xcpt_code_i(if_xcpt_code_i), .if_pc_i(if_pc_i),
    .id_illegal_i(id_illegal_i), .id_ecall_i(id_ecall_i), .id_ebreak_i(id_ebreak_i),
    .id_pc_i(id_pc_i), .id_instr_i(id_instr_i), .id_mret_i(id_mret_i),
    .mem_ld_misalign_i(mem_ld_misalign_i), .mem_st_misalign_i(mem_st_misalign_i),
    .mem_pc_i(mem_pc_i), .mem_addr_i(mem_addr_i), .mepc_i(mepc_i),
    .redirect_ready_i(redirect_ready_i),
    .xcpt_o(xcpt_o), .xcpt_code_o(xcpt_code_o), .xcpt_pc_o(xcpt_pc_o),
    .xcpt_value_o(xcpt_value_o), .flush_o(flush_o), .stall_o(stall_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  // Observed output vector: {xcpt, code, pc, value, flush, stall, rvalid, rpc}
  logic [104:0] obs;
  assign obs = {xcpt_o, xcpt_code_o, xcpt_pc_o, xcpt_value_o,
                flush_o, stall_o, redirect_valid_o, redirect_pc_o};

  function automatic logic [104:0] rec(input logic [4:0] c, input logic [31:0] p, input logic [31:0] v);
    return {1'b1, c, p, v, 1'b1, 1'b1, 1'b0, 32'd0};
  endfunction

  function automatic logic [104:0] redir(input logic [31:0] t);
    return {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, t};
  endfunction

  localparam logic [104:0] FL  = {1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 1'b0, 32'd0};
  localparam logic [104:0] IDL = 105'd0;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_inputs();
    if_xcpt_i = 0; if_xcpt_code_i = 0; if_pc_i = 0;
    id_illegal_i = 0; id_ecall_i = 0; id_ebreak_i = 0; id_mret_i = 0;
    id_pc_i = 0; id_instr_i = 0;
    mem_ld_misalign_i = 0; mem_st_misalign_i = 0; mem_pc_i = 0; mem_addr_i = 0;
    redirect_ready_i = 0;
  endtask

  task automatic test_reset();
    rstn_i = 0; clr_inputs(); mepc_i = 0;
    #2;
    n_cmp++; if (obs !== IDL) begin n_err++; $display("FAIL reset_outputs: got %h want %h", obs, IDL); end
    step(); step();
    rstn_i = 1;
    step();
    n_cmp++; if (obs !== IDL) begin n_err++; $display("FAIL reset_idle: got %h want %h", obs, IDL); end
  endtask

  task automatic test_illegal();
    id_illegal_i = 1; id_pc_i = 32'h40; id_instr_i = 32'hFFFF_FFFF;
    n_cmp++; if (obs !== IDL) begin n_err++; $display("FAIL illegal_pre: got %h want %h", obs, IDL); end
    step(); clr_inputs();
    n_cmp++; if (obs !== rec(5'd2, 32'h40, 32'hFFFF_FFFF)) begin n_err++; $display("FAIL illegal_rec: got %h want %h", obs, rec(5'd2, 32'h40, 32'hFFFF_FFFF)); end
    step();
    n_cmp++; if (obs !== FL) begin n_err++; $display("FAIL illegal_flush2: got %h want %h", obs, FL); end
    step();
    n_cmp++; if (obs !== redir(32'h100)) begin n_err++; $display("FAIL illegal_redir: got %h want %h", obs, redir(32'h100)); end
    redirect_ready_i = 1;
    step(); redirect_ready_i = 0;
    n_cmp++; if (obs !== IDL) begin n_err++; $display("FAIL illegal_idle: got %h want %h", obs, IDL); end
  endtask

  task automatic test_priority();
    mem_ld_misalign_i = 1; mem_pc_i = 32'h80; mem_addr_i = 32'h1003;
    if_xcpt_i = 1; if_xcpt_code_i = 5'd1; if_pc_i = 32'h90;
    step(); clr_inputs();
    n_cmp++; if (obs !== rec(5'd4, 32'h80, 32'h1003)) begin n_err++; $display("FAIL prio_rec: got %h want %h", obs, rec(5'd4, 32'h80, 32'h1003)); end
    step();
    n_cmp++; if (obs !== FL) begin n_err++; $display("FAIL prio_no_fetch_rec: got %h want %h", obs, FL); end
    step();
    n_cmp++; if (obs !== redir(32'h100)) begin n_err++; $display("FAIL prio_redir: got %h want %h", obs, redir(32'h100)); end
    redirect_ready_i = 1;
    step(); redirect_ready_i = 0;
    n_cmp++; if (obs !== IDL) begin n_err++; $display("FAIL prio_idle: got %h want %h", obs, IDL); end
    // Store misalign still outranks decode exceptions.
    mem_st_misalign_i = 1; mem_pc_i = 32'h84; mem_addr_i = 32'h2002;
    id_illegal_i = 1; id_pc_i = 32'h88; id_instr_i = 32'h1;
    step(); clr_inputs();
    n_cmp++; if (obs !== rec(5'd6, 32'h84, 32'h2002)) begin n_err++; $display("FAIL prio_st_rec: got %h want %h", obs, rec(5'd6, 32'h84, 32'h2002)); end
    step(); step(); redirect_ready_i = 1; step(); redirect_ready_i = 0;
    n_cmp++; if (obs !== IDL) begin n_err++; $display("FAIL prio_st_idle: got %h want %h", obs, IDL); end
  endtask

  task automatic test_mret();
    id_mret_i = 1; mepc_i = 32'h2000;
    step(); clr_inputs(); mepc_i = 32'h3000;  // target must already be latched
    n_cmp++; if (obs !== FL) begin n_err++; $display("FAIL mret_flush1: got %h want %h", obs, FL); end
    step();
    n_cmp++; if (obs !== FL) begin n_err++; $display("FAIL mret_flush2: got %h want %h", obs, FL); end
    step();
    n_cmp++; if (obs !== redir(32'h2000)) begin n_err++; $display("FAIL mret_redir: got %h want %h", obs, redir(32'h2000)); end
    redirect_ready_i = 1;
    step(); redirect_ready_i = 0;
    n_cmp++; if (obs !== IDL) begin n_err++; $display("FAIL mret_idle: got %h want %h", obs, IDL); end
  endtask

  task automatic test_mret_ecall();
    id_mret_i = 1; id_ecall_i = 1; id_pc_i = 32'h44; mepc_i = 32'h2000;
    step(); clr_inputs();
    n_cmp++; if (obs !== rec(5'd11, 32'h44, 32'h0)) begin n_err++; $display("FAIL mret_ecall_rec: got %h want %h", obs, rec(5'd11, 32'h44, 32'h0)); end
    step(); step();
    n_cmp++; if (obs !== redir(32'h100)) begin n_err++; $display("FAIL mret_ecall_redir: got %h want %h", obs, redir(32'h100)); end
    redirect_ready_i = 1;
    step(); redirect_ready_i = 0;
  endtask

  task automatic test_back_to_back();
    id_illegal_i = 1; id_pc_i = 32'h50; id_instr_i = 32'h1234;
    step();
    id_instr_i = 32'hDEAD;  // illegal held into FLUSH must be ignored
    n_cmp++; if (obs !== rec(5'd2, 32'h50, 32'h1234)) begin n_err++; $display("FAIL bp_rec: got %h want %h", obs, rec(5'd2, 32'h50, 32'h1234)); end
    step(); clr_inputs();
    n_cmp++; if (obs !== FL) begin n_err++; $display("FAIL bp_no_second_rec: got %h want %h", obs, FL); end
    step();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (obs !== redir(32'h100)) begin n_err++; $display("FAIL bp_hold%0d: got %h want %h", i, obs, redir(32'h100)); end
      step();
    end
    redirect_ready_i = 1;
    n_cmp++; if (obs !== redir(32'h100)) begin n_err++; $display("FAIL bp_handshake: got %h want %h", obs, redir(32'h100)); end
    step(); redirect_ready_i = 0;
    n_cmp++; if (obs !== IDL) begin n_err++; $display("FAIL bp_idle: got %h want %h", obs, IDL); end
    // First IDLE cycle after the handshake samples a new request.
    id_ecall_i = 1; id_pc_i = 32'h60;
    step(); clr_inputs();
    n_cmp++; if (obs !== rec(5'd11, 32'h60, 32'h0)) begin n_err++; $display("FAIL b2b_rec: got %h want %h", obs, rec(5'd11, 32'h60, 32'h0)); end
    step(); step(); redirect_ready_i = 1; step(); redirect_ready_i = 0;
  endtask

  task automatic test_reset_mid();
    id_ebreak_i = 1; id_pc_i = 32'h68;
    step(); clr_inputs();
    step();
    n_cmp++; if (obs !== FL) begin n_err++; $display("FAIL rst_mid_pre: got %h want %h", obs, FL); end
    rstn_i = 0;
    #1;
    n_cmp++; if (obs !== IDL) begin n_err++; $display("FAIL rst_mid_async: got %h want %h", obs, IDL); end
    step();
    rstn_i = 1;
    step();
    n_cmp++; if (obs !== IDL) begin n_err++; $display("FAIL rst_mid_idle: got %h want %h", obs, IDL); end
    id_ebreak_i = 1; id_pc_i = 32'h70;
    step(); clr_inputs();
    n_cmp++; if (obs !== rec(5'd3, 32'h70, 32'h0)) begin n_err++; $display("FAIL rst_mid_ebreak: got %h want %h", obs, rec(5'd3, 32'h70, 32'h0)); end
    step(); step();
    n_cmp++; if (obs !== redir(32'h100)) begin n_err++; $display("FAIL rst_mid_redir: got %h want %h", obs, redir(32'h100)); end
    redirect_ready_i = 1; step(); redirect_ready_i = 0;
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_priority();
    test_mret();
    test_mret_ecall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
